dmem_bridge: RTL and testbench

- Sits directly downstream of the pipeline's data-memory port (dmem_* bus driven by the memory execute unit).
- Converts each 64-bit-wide load/store request into one or more 16-bit beats on a narrow SRAM-style external bus with req/ack wait states.
- Returns zero-extended read data and a single completion pulse to the pipeline.
- Includes an ack timeout that reports a bus error.

---
 rtl/raisin64_mem_pkg.sv | 34 +++
 rtl/dmem_bridge.sv | 190 +++++++++++++++++++
 tb/tb_dmem_bridge.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/raisin64_mem_pkg.sv
// Shared data-memory definitions: access-width encodings, beat counts and bridge states.
package raisin64_mem_pkg;

  localparam logic [1:0] W_BYTE  = 2'd0;
  localparam logic [1:0] W_HALF  = 2'd1;
  localparam logic [1:0] W_WORD  = 2'd2;
  localparam logic [1:0] W_DWORD = 2'd3;

  localparam int unsigned DMEM_W = 64;
  localparam int unsigned BEAT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } bridge_state_e;

  // Access captured when the bridge leaves IDLE.
  typedef struct packed {
    logic [DMEM_W-1:0] dout;
    logic [1:0]        width;
    logic              write;
    logic              lane;
  } dmem_xfer_t;

  function automatic logic [2:0] beats_per_width(input logic [1:0] w);
    case (w)
      W_WORD:  return 3'd2;
      W_DWORD: return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bridge.sv
// Splits 64-bit pipeline loads/stores into 16-bit req/ack beats on a narrow SRAM bus,
// with a per-beat ack timeout that completes the access with bus_err.
module dmem_bridge
  import raisin64_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       dmem_addr,
  input  logic [63:0]       dmem_dout,
  output logic [63:0]       dmem_din,
  input  logic [1:0]        dmem_write_width,
  input  logic              dmem_rstrobe,
  input  logic              dmem_wstrobe,
  output logic              dmem_cycle_complete,
  output logic              bus_err,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic [1:0]        mem_be,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ack
);

  localparam int unsigned IW = ADDR_W - 1;
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  bridge_state_e   state_q, state_d;
  dmem_xfer_t      xfer_q, xfer_d;
  logic [IW-1:0]   base_q, base_d;
  logic [1:0]      beat_q, beat_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [63:0]     result_q, result_d;
  logic [63:0]     din_q, din_d;
  logic [IW-1:0]   addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [1:0]      be_q, be_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic            cpl_q, cpl_d;
  logic            err_q, err_d;
  logic [1:0]      last_beat;
  logic [IW-1:0]   strobe_idx;
  logic [63-ADDR_W:0] unused_addr_hi;

  assign unused_addr_hi = dmem_addr[63:ADDR_W];
  assign strobe_idx     = dmem_addr[ADDR_W-1:1];
  assign last_beat      = 2'(beats_per_width(xfer_q.width) - 3'd1);

  function automatic logic [IW-1:0] align_index(input logic [IW-1:0] idx, input logic [1:0] w);
    logic [IW-1:0] a;
    a = idx;
    if (w == W_WORD) a[0] = 1'b0;
    else if (w == W_DWORD) a[1:0] = 2'b00;
    return a;
  endfunction

  // Byte stores replicate the byte on both lanes; be selects the live one.
  function automatic logic [15:0] beat_wdata(input dmem_xfer_t x, input logic [1:0] k);
    if (x.width == W_BYTE) return {x.dout[7:0], x.dout[7:0]};
    return x.dout[{k, 4'b0000} +: 16];
  endfunction

  function automatic logic [1:0] beat_be(input dmem_xfer_t x);
    if (x.width == W_BYTE) return x.lane ? 2'b10 : 2'b01;
    return 2'b11;
  endfunction

  always_comb begin
    state_d  = state_q;
    xfer_d   = xfer_q;
    base_d   = base_q;
    beat_d   = beat_q;
    tmo_d    = tmo_q;
    result_d = result_q;
    din_d    = din_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    req_d    = req_q;
    we_d     = we_q;
    cpl_d    = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (dmem_rstrobe || dmem_wstrobe) begin
          xfer_d.dout  = dmem_dout;
          xfer_d.width = dmem_write_width;
          xfer_d.write = dmem_wstrobe;
          xfer_d.lane  = dmem_addr[0];
          base_d       = align_index(strobe_idx, dmem_write_width);
          beat_d       = 2'd0;
          tmo_d        = '0;
          result_d     = '0;
          addr_d       = base_d;
          wdata_d      = beat_wdata(xfer_d, 2'd0);
          be_d         = beat_be(xfer_d);
          req_d        = 1'b1;
          we_d         = dmem_wstrobe;
          state_d      = REQ;
        end
      end

      REQ: begin
        if (mem_ack) begin
          tmo_d = '0;
          if (!xfer_q.write) begin
            if (xfer_q.width == W_BYTE)
              result_d = {56'd0, (xfer_q.lane ? mem_rdata[15:8] : mem_rdata[7:0])};
            else
              result_d[{beat_q, 4'b0000} +: 16] = mem_rdata;
          end
          if (beat_q == last_beat) begin
            state_d = DONE;
            req_d   = 1'b0;
            we_d    = 1'b0;
            cpl_d   = 1'b1;
            if (!xfer_q.write) din_d = result_d;
          end else begin
            beat_d  = beat_q + 2'd1;
            addr_d  = base_q + IW'(beat_d);
            wdata_d = beat_wdata(xfer_q, beat_d);
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // Ack never came: finish the access with an error instead of hanging.
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          cpl_d   = 1'b1;
          err_d   = 1'b1;
          if (!xfer_q.write) din_d = '1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      xfer_q   <= '0;
      base_q   <= '0;
      beat_q   <= '0;
      tmo_q    <= '0;
      result_q <= '0;
      din_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      cpl_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      xfer_q   <= xfer_d;
      base_q   <= base_d;
      beat_q   <= beat_d;
      tmo_q    <= tmo_d;
      result_q <= result_d;
      din_q    <= din_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      req_q    <= req_d;
      we_q     <= we_d;
      cpl_q    <= cpl_d;
      err_q    <= err_d;
    end
  end

  assign dmem_din            = din_q;
  assign dmem_cycle_complete = cpl_q;
  assign bus_err             = err_q;
  assign mem_addr            = addr_q;
  assign mem_wdata           = wdata_q;
  assign mem_be              = be_q;
  assign mem_req             = req_q;
  assign mem_we              = we_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: small SRAM responder with selectable ack behaviour.
module tb_dmem_bridge;
  import raisin64_mem_pkg::*;

  localparam int unsigned ADDR_W = 24;

  logic              clk;
  logic              rst;
  logic [63:0]       dmem_addr;
  logic [63:0]       dmem_dout;
  logic [63:0]       dmem_din;
  logic [1:0]        dmem_write_width;
  logic              dmem_rstrobe;
  logic              dmem_wstrobe;
  logic              dmem_cycle_complete;
  logic              bus_err;
  logic [ADDR_W-2:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic [1:0]        mem_be;
  logic              mem_req;
  logic              mem_we;
  logic              mem_ack;

  dmem_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .dmem_addr          (dmem_addr),
    .dmem_dout          (dmem_dout),
    .dmem_din           (dmem_din),
    .dmem_write_width   (dmem_write_width),
    .dmem_rstrobe       (dmem_rstrobe),
    .dmem_wstrobe       (dmem_wstrobe),
    .dmem_cycle_complete(dmem_cycle_complete),
    .bus_err            (bus_err),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_rdata          (mem_rdata),
    .mem_be             (mem_be),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_ack            (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0 = ack tied high, 1 = ack after 3 wait cycles per beat, 2 = never ack
  int          ack_mode;
  int          wait_cnt;
  logic        loaded;
  logic [15:0] sram [0:4095];
  int          cpl_cnt;
  int          checks;
  int          failures;

  always_comb begin
    case (ack_mode)
      0:       mem_ack = 1'b1;
      1:       mem_ack = mem_req && (wait_cnt == 3);
      default: mem_ack = 1'b0;
    endcase
  end

  assign mem_rdata = sram[mem_addr[11:0]];

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 4096; i++) sram[i] <= 16'h0000;
      sram[12'h800] <= 16'h1111;
      sram[12'h801] <= 16'h2222;
      sram[12'h802] <= 16'h3333;
      sram[12'h803] <= 16'h4444;
      sram[12'h002] <= 16'hBEEF;
      sram[12'h003] <= 16'hCAFE;
      loaded <= 1'b1;
    end else if (mem_req && mem_we && mem_ack) begin
      if (mem_be[0]) sram[mem_addr[11:0]][7:0]  <= mem_wdata[7:0];
      if (mem_be[1]) sram[mem_addr[11:0]][15:8] <= mem_wdata[15:8];
    end
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (dmem_cycle_complete) cpl_cnt <= cpl_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Strobe is sampled at the next rising edge (T0); returns in the middle of T1.
  task automatic issue(input logic rd, input logic wr, input logic [63:0] a,
                       input logic [63:0] d, input logic [1:0] w);
    @(negedge clk);
    dmem_rstrobe     = rd;
    dmem_wstrobe     = wr;
    dmem_addr        = a;
    dmem_dout        = d;
    dmem_write_width = w;
    @(negedge clk);
    dmem_rstrobe = 1'b0;
    dmem_wstrobe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    int done_cyc;
    logic [63:0] a0;
    logic [63:0] a1;
    checks           = 0;
    failures         = 0;
    cpl_cnt          = 0;
    wait_cnt         = 0;
    loaded           = 1'b0;
    ack_mode         = 0;
    rst              = 1'b1;
    dmem_addr        = '0;
    dmem_dout        = '0;
    dmem_write_width = W_BYTE;
    dmem_rstrobe     = 1'b0;
    dmem_wstrobe     = 1'b0;

    repeat (2) step();
    chk("rst_req",  64'(mem_req), 64'd0);
    chk("rst_cpl",  64'(dmem_cycle_complete), 64'd0);
    chk("rst_err",  64'(bus_err), 64'd0);
    chk("rst_din",  dmem_din, 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_be",   64'(mem_be), 64'd0);
    rst = 1'b0;
    step();

    // Dword read, ack tied high: beats T1..T4, complete T5
    ack_mode = 0;
    issue(1'b1, 1'b0, 64'h1000, 64'd0, W_DWORD);
    for (int i = 0; i < 4; i++) begin
      chk("dw_req",  64'(mem_req), 64'd1);
      chk("dw_addr", 64'(mem_addr), 64'(32'h800 + i));
      chk("dw_cpl",  64'(dmem_cycle_complete), 64'd0);
      step();
    end
    chk("dw_cpl_t5", 64'(dmem_cycle_complete), 64'd1);
    chk("dw_din",    dmem_din, 64'h4444_3333_2222_1111);
    chk("dw_err",    64'(bus_err), 64'd0);
    step();
    chk("dw_cpl_t6", 64'(dmem_cycle_complete), 64'd0);
    chk("dw_req_t6", 64'(mem_req), 64'd0);

    // Byte write to upper lane of halfword 0x1001
    snap = cpl_cnt;
    issue(1'b0, 1'b1, 64'h2003, 64'hFFFF_0000_1234_56AB, W_BYTE);
    chk("bw_req",   64'(mem_req), 64'd1);
    chk("bw_we",    64'(mem_we), 64'd1);
    chk("bw_addr",  64'(mem_addr), 64'h1001);
    chk("bw_be",    64'(mem_be), 64'd2);
    chk("bw_wdata", 64'(mem_wdata), 64'hABAB);
    step();
    chk("bw_cpl",   64'(dmem_cycle_complete), 64'd1);
    chk("bw_din",   dmem_din, 64'h4444_3333_2222_1111);
    step();
    chk("bw_cpl_off", 64'(dmem_cycle_complete), 64'd0);
    chk("bw_cnt",   64'(cpl_cnt - snap), 64'd1);
    chk("bw_sram",  64'(sram[12'h001]), 64'hAB00);

    // Word read with three wait cycles per beat
    ack_mode = 1;
    done_cyc = 0;
    a0 = '1;
    a1 = '1;
    issue(1'b1, 1'b0, 64'h0006, 64'd0, W_WORD);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc == 1) a0 = 64'(mem_addr);
      if (cyc == 5) a1 = 64'(mem_addr);
      if (dmem_cycle_complete) begin
        done_cyc = cyc;
        break;
      end
      step();
    end
    chk("wr_addr0", a0, 64'h2);
    chk("wr_addr1", a1, 64'h3);
    chk("wr_cyc",   64'(done_cyc), 64'd9);
    chk("wr_din",   dmem_din, 64'h0000_0000_CAFE_BEEF);
    step();

    // Half read with no ack: timeout after 4 REQ cycles
    ack_mode = 2;
    issue(1'b1, 1'b0, 64'h0010, 64'd0, W_HALF);
    for (int i = 0; i < 4; i++) begin
      chk("to_req",  64'(mem_req), 64'd1);
      chk("to_addr", 64'(mem_addr), 64'h8);
      chk("to_cpl",  64'(dmem_cycle_complete), 64'd0);
      step();
    end
    chk("to_cpl_t5", 64'(dmem_cycle_complete), 64'd1);
    chk("to_err_t5", 64'(bus_err), 64'd1);
    chk("to_din",    dmem_din, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("to_req_t5", 64'(mem_req), 64'd0);
    step();
    chk("to_cpl_t6", 64'(dmem_cycle_complete), 64'd0);
    chk("to_err_t6", 64'(bus_err), 64'd0);

    // Both strobes (write wins), extra strobe during REQ ignored
    ack_mode = 0;
    snap = cpl_cnt;
    issue(1'b1, 1'b1, 64'h0020, 64'h0000_0000_5555_6666, W_WORD);
    chk("bs_we0",    64'(mem_we), 64'd1);
    chk("bs_addr0",  64'(mem_addr), 64'h10);
    chk("bs_wdata0", 64'(mem_wdata), 64'h6666);
    dmem_rstrobe     = 1'b1;
    dmem_addr        = 64'h0040;
    dmem_write_width = W_DWORD;
    step();
    dmem_rstrobe = 1'b0;
    chk("bs_we1",    64'(mem_we), 64'd1);
    chk("bs_addr1",  64'(mem_addr), 64'h11);
    chk("bs_wdata1", 64'(mem_wdata), 64'h5555);
    step();
    chk("bs_cpl",    64'(dmem_cycle_complete), 64'd1);
    step();
    chk("bs_req_after", 64'(mem_req), 64'd0);
    repeat (3) step();
    chk("bs_cnt",    64'(cpl_cnt - snap), 64'd1);
    chk("bs_sram0",  64'(sram[12'h010]), 64'h6666);
    chk("bs_sram1",  64'(sram[12'h011]), 64'h5555);
    chk("bs_din",    dmem_din, 64'hFFFF_FFFF_FFFF_FFFF);

    // Reset during beat 2 of a dword write
    ack_mode = 1;
    issue(1'b0, 1'b1, 64'h0100, 64'h4444_3333_2222_1111, W_DWORD);
    repeat (4) step();
    chk("rs_addr_b2", 64'(mem_addr), 64'h81);
    chk("rs_req_b2",  64'(mem_req), 64'd1);
    step();
    rst = 1'b1;
    #1;
    chk("rs_req_async",  64'(mem_req), 64'd0);
    chk("rs_addr_async", 64'(mem_addr), 64'd0);
    chk("rs_din_async",  dmem_din, 64'd0);
    snap = cpl_cnt;
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("rs_no_cpl", 64'(cpl_cnt - snap), 64'd0);
    chk("rs_sram0",  64'(sram[12'h080]), 64'h1111);
    chk("rs_sram1",  64'(sram[12'h081]), 64'h0000);

    // Byte read from upper lane after reset
    ack_mode = 0;
    issue(1'b1, 1'b0, 64'h0021, 64'd0, W_BYTE);
    chk("br_addr", 64'(mem_addr), 64'h10);
    chk("br_be",   64'(mem_be), 64'd2);
    chk("br_we",   64'(mem_we), 64'd0);
    step();
    chk("br_cpl",  64'(dmem_cycle_complete), 64'd1);
    chk("br_din",  dmem_din, 64'h66);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
